// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker: polynomial tap table,
// checker state encoding and the supported word-width ceiling.
package prbs_pkg;

    localparam int unsigned MAX_DATA_W = 64;

    typedef enum logic {
        HUNT,
        LOCKED
    } chk_state_e;

    // Second tap of x^ORDER + x^TAP + 1; returns 0 for unsupported orders.
    function automatic int unsigned prbs_tap(input int unsigned order);
        case (order)
            5:       return 3;
            7:       return 6;
            9:       return 5;
            15:      return 14;
            23:      return 18;
            31:      return 28;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational multi-bit Fibonacci LFSR advance: DATA_W steps of
// x^ORDER + x^TAP + 1, state bit 0 newest, bits_o[0] earliest.
module prbs_step #(
    parameter int unsigned ORDER  = 7,
    parameter int unsigned TAP    = 6,
    parameter int unsigned DATA_W = 1
) (
    input  logic [ORDER-1:0]  state_i,
    output logic [ORDER-1:0]  state_o,
    output logic [DATA_W-1:0] bits_o
);

    always_comb begin
        state_o = state_i;
        bits_o  = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            bits_o[i] = state_o[ORDER-1] ^ state_o[TAP-1];
            state_o   = {state_o[ORDER-2:0], bits_o[i]};
        end
    end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS pattern generator with seed load and one-shot error injection, plus a
// self-synchronising checker with lock FSM and saturating bit-error counter.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int unsigned ORDER     = 7,
    parameter int unsigned DATA_W    = 1,
    parameter int unsigned LOCK_CNT  = 16,
    parameter int unsigned LOSS_CNT  = 4,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_seed_load,
    input  logic [ORDER-1:0]     i_seed,
    input  logic                 i_inject_err,
    output logic [DATA_W-1:0]    o_prbs,
    output logic                 o_valid,
    input  logic                 i_chk_valid,
    input  logic [DATA_W-1:0]    i_chk_data,
    input  logic                 i_err_clr,
    output logic                 o_locked,
    output logic                 o_word_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int unsigned TAP   = prbs_tap(ORDER);
    localparam int unsigned FC_W  = $clog2(ORDER + 1);
    localparam int unsigned LK_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned LS_W  = $clog2(LOSS_CNT + 1);
    localparam int unsigned PC_W  = $clog2(DATA_W + 1);
    localparam int unsigned SUM_W = ((ERR_CNT_W > PC_W) ? ERR_CNT_W : PC_W) + 1;

    localparam logic [FC_W-1:0] ORDER_C = FC_W'(ORDER);
    localparam logic [LK_W-1:0] LOCK_M1 = LK_W'(LOCK_CNT - 1);
    localparam logic [LS_W-1:0] LOSS_M1 = LS_W'(LOSS_CNT - 1);

    if (TAP == 0) begin : g_bad_order
        $error("prbs_gen_chk: unsupported ORDER %0d", ORDER);
    end
    if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_width
        $error("prbs_gen_chk: DATA_W %0d out of range", DATA_W);
    end

    // ---------------- generator ----------------
    logic [ORDER-1:0]  gen_q, gen_d, step_state;
    logic [DATA_W-1:0] step_bits, prbs_q, prbs_d;
    logic              valid_q, valid_d, inj_q, inj_d, inj_now;

    prbs_step #(
        .ORDER  (ORDER),
        .TAP    (TAP),
        .DATA_W (DATA_W)
    ) u_step (
        .state_i (gen_q),
        .state_o (step_state),
        .bits_o  (step_bits)
    );

    always_comb begin
        gen_d   = gen_q;
        prbs_d  = prbs_q;
        valid_d = 1'b0;
        inj_now = inj_q | i_inject_err;
        inj_d   = inj_now;
        if (i_seed_load) begin
            gen_d = (i_seed == '0) ? ORDER'(1) : i_seed;
        end else if (i_en) begin
            // Injection flips the emitted bit only; the LFSR keeps the true sequence.
            gen_d   = step_state;
            prbs_d  = step_bits ^ DATA_W'(inj_now);
            valid_d = 1'b1;
            inj_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_q   <= ORDER'(1);
            prbs_q  <= '0;
            valid_q <= 1'b0;
            inj_q   <= 1'b0;
        end else begin
            gen_q   <= gen_d;
            prbs_q  <= prbs_d;
            valid_q <= valid_d;
            inj_q   <= inj_d;
        end
    end

    // ---------------- checker datapath ----------------
    logic [ORDER-1:0]     hist_q, hist_d, hist_w;
    logic [DATA_W-1:0]    mis;
    logic [FC_W-1:0]      fill_q, fill_d, fill_w, zrun_q, zrun_d, zrun_w;
    logic [PC_W-1:0]      pc;
    logic [LK_W-1:0]      lock_q, lock_d;
    logic [LS_W-1:0]      loss_q, loss_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]     sum;
    logic                 werr_q, werr_d, go_hunt;
    chk_state_e           state_q, state_d;

    // Predictions come from received history, so a line error shows up three times.
    always_comb begin
        hist_w = hist_q;
        zrun_w = zrun_q;
        fill_w = fill_q;
        mis    = '0;
        pc     = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            mis[i] = i_chk_data[i] ^ hist_w[ORDER-1] ^ hist_w[TAP-1];
            hist_w = {hist_w[ORDER-2:0], i_chk_data[i]};
            if (i_chk_data[i])
                zrun_w = '0;
            else if (zrun_w != ORDER_C)
                zrun_w = zrun_w + FC_W'(1);
            if (fill_w != ORDER_C)
                fill_w = fill_w + FC_W'(1);
            pc = pc + PC_W'(mis[i]);
        end
    end

    // ---------------- checker FSM ----------------
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        loss_d  = loss_q;
        hist_d  = hist_q;
        zrun_d  = zrun_q;
        fill_d  = fill_q;
        werr_d  = werr_q;
        cnt_d   = i_err_clr ? '0 : cnt_q;
        sum     = '0;
        go_hunt = 1'b0;
        if (i_chk_valid) begin
            hist_d = hist_w;
            zrun_d = zrun_w;
            fill_d = fill_w;
            werr_d = (state_q == LOCKED) && (mis != '0);
            case (state_q)
                HUNT: begin
                    if (mis == '0 && fill_q == ORDER_C && hist_w != '0) begin
                        lock_d = lock_q + LK_W'(1);
                        if (lock_q == LOCK_M1) begin
                            state_d = LOCKED;
                            lock_d  = '0;
                            loss_d  = '0;
                        end
                    end else begin
                        lock_d = '0;
                    end
                end
                LOCKED: begin
                    sum   = SUM_W'(cnt_d) + SUM_W'(pc);
                    cnt_d = (|sum[SUM_W-1:ERR_CNT_W]) ? '1 : sum[ERR_CNT_W-1:0];
                    if (zrun_w == ORDER_C)
                        go_hunt = 1'b1;
                    else if (mis != '0) begin
                        if (loss_q == LOSS_M1)
                            go_hunt = 1'b1;
                        else
                            loss_d = loss_q + LS_W'(1);
                    end else
                        loss_d = '0;
                end
            endcase
            // History survives re-hunting; only the run and fill counters restart.
            if (go_hunt) begin
                state_d = HUNT;
                lock_d  = '0;
                loss_d  = '0;
                fill_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            hist_q  <= '0;
            zrun_q  <= '0;
            fill_q  <= '0;
            lock_q  <= '0;
            loss_q  <= '0;
            werr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            zrun_q  <= zrun_d;
            fill_q  <= fill_d;
            lock_q  <= lock_d;
            loss_q  <= loss_d;
            werr_q  <= werr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_prbs     = prbs_q;
    assign o_valid    = valid_q;
    assign o_locked   = (state_q == LOCKED);
    assign o_word_err = werr_q;
    assign o_err_cnt  = cnt_q;

endmodule
